// File: rtl/thermo_pkg.sv
// Shared types and helpers for the thermostat controller.
// Temperatures and hysteresis are unsigned, in 0.5 C units.
package thermo_pkg;

  localparam int unsigned TEMP_W = 8;
  localparam int unsigned HYST_W = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHeating = 2'd1,
    StCooling = 2'd2,
    StLockout = 2'd3
  } thermo_state_e;

  // Lower band edge; a borrow out of the 9-bit difference means the result went negative.
  function automatic logic [TEMP_W-1:0] band_lo(input logic [TEMP_W-1:0] sp,
                                                input logic [HYST_W-1:0] hy);
    logic [TEMP_W:0] diff;
    diff = {1'b0, sp} - {{(TEMP_W - HYST_W + 1){1'b0}}, hy};
    return diff[TEMP_W] ? '0 : diff[TEMP_W-1:0];
  endfunction

  function automatic logic [TEMP_W-1:0] band_hi(input logic [TEMP_W-1:0] sp,
                                                input logic [HYST_W-1:0] hy);
    logic [TEMP_W:0] sum;
    sum = {1'b0, sp} + {{(TEMP_W - HYST_W + 1){1'b0}}, hy};
    return sum[TEMP_W] ? '1 : sum[TEMP_W-1:0];
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Rising-edge detector turning the divided slow_clk level into a one-cycle tick
// in the main_clk domain.
module tick_gen (
  input  logic main_clk_i,
  input  logic reset_i,
  input  logic slow_clk_i,
  output logic tick_o
);

  logic slow_clk_q;

  // The divider output resets high, so start high to avoid a spurious first tick.
  always_ff @(posedge main_clk_i) begin
    if (reset_i) begin
      slow_clk_q <= 1'b1;
    end else begin
      slow_clk_q <= slow_clk_i;
    end
  end

  assign tick_o = slow_clk_i & ~slow_clk_q;

endmodule

// File: rtl/thermostat_ctrl.sv
// Thermostat controller: hysteresis heat/cool FSM with minimum run/rest times and
// stale-sensor lockout. Define THERMO_COOL_EN to enable the cooling path.
module thermostat_ctrl
  import thermo_pkg::*;
#(
  parameter int unsigned MIN_TICKS   = 200,
  parameter int unsigned STALE_TICKS = 1000
) (
  input  logic              main_clk,
  input  logic              reset,
  input  logic              slow_clk,
  input  logic              temp_valid,
  input  logic [TEMP_W-1:0] temp_in,
  input  logic [TEMP_W-1:0] setpoint,
  input  logic [HYST_W-1:0] hyst,
  output logic              heat_on,
  output logic              cool_on,
  output logic [1:0]        state,
  output logic              fault
);

  localparam int unsigned RunW   = $clog2(MIN_TICKS + 1);
  localparam int unsigned StaleW = $clog2(STALE_TICKS + 1);

  logic                tick;
  logic [TEMP_W-1:0]   temp_q;
  thermo_state_e       state_q, state_d;
  logic [RunW-1:0]     run_cnt_q, run_cnt_d;
  logic [StaleW-1:0]   stale_cnt_q, stale_cnt_d;
  logic                fault_q, fault_d;
  logic                heat_q, heat_d;
  logic                cool_q, cool_d;
  logic [TEMP_W-1:0]   lo;
  logic                run_done;
  logic                stale_hit;
`ifdef THERMO_COOL_EN
  logic [TEMP_W-1:0]   hi;
`endif

  tick_gen u_tick_gen (
    .main_clk_i (main_clk),
    .reset_i    (reset),
    .slow_clk_i (slow_clk),
    .tick_o     (tick)
  );

  assign lo = band_lo(setpoint, hyst);
`ifdef THERMO_COOL_EN
  assign hi = band_hi(setpoint, hyst);
`endif

  assign run_done  = (run_cnt_q >= RunW'(MIN_TICKS));
  // A temp_valid in the expiry cycle restarts the count instead of faulting.
  assign stale_hit = tick && !temp_valid && (stale_cnt_q == StaleW'(STALE_TICKS - 1));

  // State register and datapath registers.
  always_ff @(posedge main_clk) begin
    if (reset) begin
      state_q     <= StIdle;
      temp_q      <= '0;
      run_cnt_q   <= '0;
      stale_cnt_q <= '0;
      fault_q     <= 1'b0;
      heat_q      <= 1'b0;
      cool_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      run_cnt_q   <= run_cnt_d;
      stale_cnt_q <= stale_cnt_d;
      fault_q     <= fault_d;
      heat_q      <= heat_d;
      cool_q      <= cool_d;
      if (temp_valid) begin
        temp_q <= temp_in;
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (temp_q < lo) begin
          state_d = StHeating;
        end
`ifdef THERMO_COOL_EN
        else if (temp_q > hi) begin
          state_d = StCooling;
        end
`endif
      end
      StHeating: begin
        if ((temp_q >= setpoint) && run_done) begin
          state_d = StLockout;
        end
      end
      StCooling: begin
        if ((temp_q <= setpoint) && run_done) begin
          state_d = StLockout;
        end
      end
      StLockout: begin
        if (run_done && !fault_q) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (stale_hit) begin
      state_d = StLockout;
    end
  end

  // Counters and fault flag.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (state_d != state_q) begin
      run_cnt_d = '0;
    end else if (tick && !run_done) begin
      run_cnt_d = run_cnt_q + RunW'(1);
    end

    stale_cnt_d = stale_cnt_q;
    if (temp_valid) begin
      stale_cnt_d = '0;
    end else if (tick && (stale_cnt_q != StaleW'(STALE_TICKS))) begin
      stale_cnt_d = stale_cnt_q + StaleW'(1);
    end

    fault_d = fault_q;
    if (temp_valid) begin
      fault_d = 1'b0;
    end else if (stale_hit) begin
      fault_d = 1'b1;
    end
  end

  // Output decode, registered alongside the state.
  always_comb begin
    heat_d = (state_d == StHeating);
`ifdef THERMO_COOL_EN
    cool_d = (state_d == StCooling);
`else
    cool_d = 1'b0;
`endif
  end

  assign heat_on = heat_q;
  assign cool_on = cool_q;
  assign state   = state_q;
  assign fault   = fault_q;

endmodule

// File: tb/tb_thermostat_ctrl.sv
// Self-checking bench for thermostat_ctrl (MIN_TICKS=4, STALE_TICKS=20); expectations
// follow the THERMO_COOL_EN setting of the build.
module tb_thermostat_ctrl;

  logic       main_clk = 1'b0;
  logic       reset = 1'b1;
  logic       slow_clk = 1'b1;
  logic       temp_valid = 1'b0;
  logic [7:0] temp_in = '0;
  logic [7:0] setpoint = '0;
  logic [3:0] hyst = '0;
  logic       heat_on, cool_on, fault;
  logic [1:0] state;

  // Packed {state, heat_on, cool_on, fault}.
  localparam logic [4:0] E_IDLE  = 5'b00_0_0_0;
  localparam logic [4:0] E_HEAT  = 5'b01_1_0_0;
  localparam logic [4:0] E_COOL  = 5'b10_0_1_0;
  localparam logic [4:0] E_LOCK  = 5'b11_0_0_0;
  localparam logic [4:0] E_LOCKF = 5'b11_0_0_1;

  typedef struct {
    string      name;
    logic [4:0] v;
  } exp_t;

  exp_t exp_q[$];
  int   n_vec = 0;
  int   n_bad = 0;

  thermostat_ctrl #(
    .MIN_TICKS   (4),
    .STALE_TICKS (20)
  ) dut (
    .main_clk   (main_clk),
    .reset      (reset),
    .slow_clk   (slow_clk),
    .temp_valid (temp_valid),
    .temp_in    (temp_in),
    .setpoint   (setpoint),
    .hyst       (hyst),
    .heat_on    (heat_on),
    .cool_on    (cool_on),
    .state      (state),
    .fault      (fault)
  );

  always #5 main_clk = ~main_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic step();
    @(posedge main_clk);
    #1;
  endtask

  // One slow_clk rising edge; the tick is seen at the second main_clk edge.
  task automatic tick_pulse();
    slow_clk = 1'b0;
    step();
    slow_clk = 1'b1;
    step();
  endtask

  task automatic send(input logic [7:0] t);
    temp_valid = 1'b1;
    temp_in    = t;
    step();
    temp_valid = 1'b0;
  endtask

  // Reset, then load temp_q while the band is [0,0] so IDLE holds, then apply sp/hy.
  task automatic preload(input logic [7:0] t, input logic [7:0] sp, input logic [3:0] hy);
    reset    = 1'b1;
    setpoint = '0;
    hyst     = '0;
    slow_clk = 1'b1;
    step();
    step();
    reset = 1'b0;
    send(t);
    setpoint = sp;
    hyst     = hy;
    step();
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    exp_q.push_back('{"reset_state", E_IDLE});
    step();
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    reset = 1'b0;
  endtask

  task automatic test_heat();
    exp_t e;
    preload(8'd40, 8'd40, 4'd2);
    exp_q.push_back('{"heat_lat1_idle", E_IDLE});
    exp_q.push_back('{"heat_lat2_on", E_HEAT});
    send(8'd37);
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
  endtask

  task automatic test_min_run();
    exp_t e;
    tick_pulse();
    tick_pulse();
    exp_q.push_back('{"minrun_hold_at_sp", E_HEAT});
    send(8'd41);
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    exp_q.push_back('{"minrun_tick4_heat", E_HEAT});
    exp_q.push_back('{"minrun_lockout", E_LOCK});
    tick_pulse();
    tick_pulse();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    exp_q.push_back('{"rest_tick4_lock", E_LOCK});
    exp_q.push_back('{"rest_to_idle", E_IDLE});
    for (int i = 0; i < 4; i++) tick_pulse();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
  endtask

  task automatic test_stale();
    exp_t e;
    exp_q.push_back('{"stale_19_heat", E_HEAT});
    exp_q.push_back('{"stale_20_fault", E_LOCKF});
    send(8'd37);
    step();
    for (int i = 0; i < 19; i++) tick_pulse();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    tick_pulse();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    exp_q.push_back('{"stale_fault_clear", E_LOCK});
    exp_q.push_back('{"stale_rest_lock", E_LOCK});
    exp_q.push_back('{"stale_to_idle", E_IDLE});
    send(8'd40);
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    for (int i = 0; i < 4; i++) tick_pulse();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
  endtask

  task automatic test_stale_coincide();
    exp_t e;
    exp_q.push_back('{"coincide_no_fault", E_IDLE});
    exp_q.push_back('{"coincide_after", E_IDLE});
    send(8'd40);
    for (int i = 0; i < 19; i++) tick_pulse();
    slow_clk = 1'b0;
    step();
    slow_clk   = 1'b1;
    temp_valid = 1'b1;
    temp_in    = 8'd40;
    step();
    temp_valid = 1'b0;
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    tick_pulse();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
  endtask

  // Lowering the setpoint mid-run must not restart the minimum run time.
  task automatic test_setpoint_change();
    exp_t e;
    exp_q.push_back('{"sp_heat_start", E_HEAT});
    exp_q.push_back('{"sp_changed_hold", E_HEAT});
    exp_q.push_back('{"sp_lockout_on_time", E_LOCK});
    send(8'd37);
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    tick_pulse();
    tick_pulse();
    setpoint = 8'd36;
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    tick_pulse();
    tick_pulse();
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
  endtask

  task automatic test_saturation();
    exp_t e;
    exp_q.push_back('{"sat_hi_no_cool", E_IDLE});
    preload(8'd255, 8'd254, 4'd5);
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    exp_q.push_back('{"sat_lo_no_heat", E_IDLE});
    preload(8'd0, 8'd2, 4'd5);
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
  endtask

  task automatic test_cool();
    exp_t e;
    preload(8'd40, 8'd40, 4'd2);
`ifdef THERMO_COOL_EN
    exp_q.push_back('{"cool_lat1_idle", E_IDLE});
    exp_q.push_back('{"cool_lat2_on", E_COOL});
`else
    exp_q.push_back('{"nocool_lat1_idle", E_IDLE});
    exp_q.push_back('{"nocool_stay_idle", E_IDLE});
`endif
    send(8'd60);
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    step();
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
  endtask

  task automatic test_reset_mid_run();
    exp_t e;
    preload(8'd40, 8'd40, 4'd2);
    exp_q.push_back('{"mid_heat", E_HEAT});
    exp_q.push_back('{"mid_reset_drop", E_IDLE});
    send(8'd37);
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    reset = 1'b1;
    step();
    e = exp_q.pop_front(); n_vec++;
    if ({state, heat_on, cool_on, fault} !== e.v) begin
      n_bad++; $display("FAIL %s: got %b want %b", e.name, {state, heat_on, cool_on, fault}, e.v);
    end
    reset = 1'b0;
  endtask

  initial begin
    test_reset();
    test_heat();
    test_min_run();
    test_stale();
    test_stale_coincide();
    test_setpoint_change();
    test_saturation();
    test_cool();
    test_reset_mid_run();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/thermostat_ctrl.md
THERMOSTAT_CTRL -- requirements
Module: thermostat_ctrl

Interface
REQ-001 SHALL have parameter MIN_TICKS, default 200, minimum run time and minimum rest time in slow_clk rising edges.
REQ-002 SHALL have parameter STALE_TICKS, default 1000, slow_clk rising edges without temp_valid before a fault is raised.
REQ-003 SHALL have port main_clk, input, 1, the only clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port slow_clk, input, 1, divided clock level from the divider, sampled as a data signal in the main_clk domain, never used as a clock.
REQ-006 SHALL have port temp_valid, input, 1, single-cycle strobe qualifying temp_in.
REQ-007 SHALL have port temp_in, input, 8, unsigned temperature in 0.5 C units.
REQ-008 SHALL have port setpoint, input, 8, unsigned target in 0.5 C units, sampled continuously.
REQ-009 SHALL have port hyst, input, 4, unsigned hysteresis band in 0.5 C units.
REQ-010 SHALL have port heat_on, output, 1, heater drive, registered.
REQ-011 SHALL have port cool_on, output, 1, cooler drive, registered.
REQ-012 SHALL have port state, output, 2, current FSM state encoding.
REQ-013 SHALL have port fault, output, 1, stale-sensor indication, registered.

Function
REQ-014 SHALL derive tick = slow_clk & ~slow_clk_d, with slow_clk_d a main_clk register; tick SHALL be asserted exactly one main_clk cycle per slow_clk rising edge.
REQ-015 SHALL latch temp_in into temp_q on the cycle temp_valid is high; the FSM SHALL use temp_q one cycle later, giving 2-cycle temp_valid-to-output latency.
REQ-016 SHALL compute lo = setpoint - hyst, saturating at 0, and hi = setpoint + hyst, saturating at 255, in 9-bit arithmetic with no wrap-around.
REQ-017 SHALL implement the states IDLE=0, HEATING=1, COOLING=2 and LOCKOUT=3; heat_on SHALL be 1 only in HEATING and cool_on SHALL be 1 only in COOLING.
REQ-018 IDLE: go to HEATING if temp_q < lo, else to COOLING if temp_q > hi, else stay.
REQ-019 HEATING: go to LOCKOUT when temp_q >= setpoint and run_cnt >= MIN_TICKS; otherwise stay, even if the setpoint is reached.
REQ-020 COOLING: go to LOCKOUT when temp_q <= setpoint and run_cnt >= MIN_TICKS.
REQ-021 LOCKOUT: go to IDLE when run_cnt >= MIN_TICKS and fault = 0.
REQ-022 run_cnt SHALL clear on every state change, increment on tick, and saturate at MIN_TICKS.
REQ-023 stale_cnt SHALL clear on temp_valid and increment on tick; when it reaches STALE_TICKS, fault SHALL set and the FSM SHALL enter LOCKOUT from any state, overriding the minimum run time.
REQ-024 fault SHALL clear on the next temp_valid; if temp_valid and stale expiry coincide, temp_valid SHALL win and no fault SHALL be raised.
REQ-025 Setpoint or hyst changes mid-run SHALL take effect on the next cycle without resetting run_cnt.

Reset
REQ-026 On reset, the block SHALL set state=IDLE, heat_on=0, cool_on=0, fault=0, temp_q=0, run_cnt=0, stale_cnt=0 and slow_clk_d=1.
REQ-027 slow_clk_d=1 at reset SHALL suppress a spurious tick, since the divider output resets high.
REQ-028 Reset asserted mid-run SHALL drop heat_on and cool_on on the next edge.

Configuration
REQ-029 With macro THERMO_COOL_EN defined, COOLING SHALL be reachable as specified.
REQ-030 Without THERMO_COOL_EN, cool_on SHALL be tied to 0, COOLING SHALL be unreachable, and temp_q > hi in IDLE SHALL keep the FSM in IDLE.

Structure
REQ-031 Package thermo_pkg SHALL hold the state encodings, TEMP_W=8 and HYST_W=4.
REQ-032 Sub-module tick_gen SHALL hold the slow_clk edge detector; all other logic SHALL live in thermostat_ctrl.

Verification (MIN_TICKS=4, STALE_TICKS=20, THERMO_COOL_EN defined unless noted)
REQ-033 setpoint=40, hyst=2, temp=37 -> heat_on=1 two cycles after temp_valid, with state=1.
REQ-034 While heating, temp=41 after 2 ticks -> heat_on stays 1 until the 4th tick, then LOCKOUT, then IDLE 4 ticks later.
REQ-035 setpoint=254, hyst=5, temp=255 -> no COOLING (hi saturates at 255); setpoint=2, hyst=5, temp=0 -> HEATING is not entered (lo saturates at 0, and temp_q < lo is false).
REQ-036 No temp_valid for 20 ticks while HEATING -> fault=1, heat_on=0 and LOCKOUT; next temp_valid -> fault=0, then IDLE after 4 ticks.
REQ-037 temp_valid in the same cycle as the 20th tick -> fault stays 0.
REQ-038 Without THERMO_COOL_EN, temp=60 and setpoint=40 -> cool_on=0 and state=0 throughout.
